dmem_responder: RTL and testbench

- Memory-side responder for the load/store path: accepts load/store requests over a valid/ready channel, services them from an internal word array after a fixed latency, and returns read data/status over a valid/ready response channel.
- Sits between the load/store unit (initiator) and the data storage. Replaces ad-hoc direct array access with a stallable, latency-modelled data memory.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE    = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage: byte-enable synchronous write, registered read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic            re,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [BE_W-1:0] be,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rdata_q;

    // No reset on the storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Latency-modelled data memory behind valid/ready request and response channels.
// Optional access statistics are built when DMEM_STATS_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
`ifdef DMEM_STATS_EN
    ,
    input  logic            stat_clr,
    output logic [15:0]     stat_loads,
    output logic [15:0]     stat_stores,
    output logic [15:0]     stat_errs
`endif
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      fault_q, fault_d;
    logic            we_q, we_d;

    logic            accept;
    logic [1:0]      fault_now;
    logic            arr_we, arr_re;
    logic [XLEN-1:0] arr_rdata;

    assign accept = req_valid && req_ready;

    always_comb begin
        fault_now = FAULT_NONE;
        if (req_addr[1:0] != 2'b00) begin
            fault_now = FAULT_MISALIGN;
        end else if (req_addr[31:2] >= 30'(DEPTH)) begin
            fault_now = FAULT_RANGE;
        end
    end

    // The array is touched only on a fault-free accept edge, so its read
    // register keeps the load data stable for the whole response.
    assign arr_we = accept && req_we  && (fault_now == FAULT_NONE);
    assign arr_re = accept && !req_we && (fault_now == FAULT_NONE);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (req_addr[AW+1:2]),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            fault_q <= FAULT_NONE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    fault_d = fault_now;
                    we_d    = req_we;
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    fault_d = FAULT_NONE;
                    we_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = (state_q == RESP) && (fault_q != FAULT_NONE);
        rsp_rdata = '0;
        if ((state_q == RESP) && (fault_q == FAULT_NONE) && !we_q) begin
            rsp_rdata = arr_rdata;
        end
    end

`ifdef DMEM_STATS_EN
    logic [2:0] stat_inc;

    assign stat_inc[0] = accept && (fault_now == FAULT_NONE) && !req_we;
    assign stat_inc[1] = accept && (fault_now == FAULT_NONE) && req_we;
    assign stat_inc[2] = accept && (fault_now != FAULT_NONE);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [15:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (stat_clr) begin
                    cnt_d = '0;
                end else if (stat_inc[gi] && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign stat_loads  = g_stat[0].cnt_q;
    assign stat_stores = g_stat[1].cnt_q;
    assign stat_errs   = g_stat[2].cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2/DEPTH=256 instance and a
// LATENCY=0/DEPTH=16 instance for back-to-back traffic (stats when DMEM_STATS_EN).
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0, req_we = 1'b0, req_ready;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0, req_ready0;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic [3:0]  req_be0 = '0;
    logic        rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

`ifdef DMEM_STATS_EN
    logic        stat_clr = 1'b0, stat_clr0 = 1'b0;
    logic [15:0] stat_loads, stat_stores, stat_errs;
    logic [15:0] stat_loads0, stat_stores0, stat_errs0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
        , .stat_clr(stat_clr), .stat_loads(stat_loads),
        .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
    );

    dmem_responder #(.DEPTH(16), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(1'b1),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
`ifdef DMEM_STATS_EN
        , .stat_clr(stat_clr0), .stat_loads(stat_loads0),
        .stat_stores(stat_stores0), .stat_errs(stat_errs0)
`endif
    );

    // Drives one request on the LATENCY=2 instance and returns what came back.
    // lat = posedges from accept edge to first rsp_valid, or -1 on timeout.
    task automatic run_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output int lat, output logic [31:0] rdata,
                            output logic err, output logic idle_after);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = $urandom; req_be = 4'hF;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!rsp_valid) lat = -1;
        rdata = rsp_rdata;
        err = rsp_err;
        @(posedge clk);
        @(negedge clk);
        idle_after = req_ready && !rsp_valid && (rsp_rdata == 32'h0) && !rsp_err;
        $display("xact we=%0b addr=%08h wdata=%08h be=%04b -> lat=%0d rdata=%08h err=%0b idle_after=%0b",
                 we, addr, wdata, be, lat, rdata, err, idle_after);
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        vectors++;
        if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata got=%08h want=0", rsp_rdata); end
        vectors++;
        if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
        vectors++;
        if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
            miscompares++; $display("FAIL reset_lat0 got ready=%b valid=%b want ready=1 valid=0", req_ready0, rsp_valid0);
        end
    endtask

    task automatic test_store_load;
        int lat; logic [31:0] rd; logic er, idle;
        run_xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er, idle);
        vectors++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0 || idle !== 1'b1) begin
            miscompares++;
            $display("FAIL store_full got lat=%0d rdata=%08h err=%b idle=%b want lat=2 rdata=0 err=0 idle=1", lat, rd, er, idle);
        end
        run_xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, idle);
        vectors++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || idle !== 1'b1) begin
            miscompares++;
            $display("FAIL load_full got lat=%0d rdata=%08h err=%b idle=%b want lat=2 rdata=deadbeef err=0 idle=1", lat, rd, er, idle);
        end
    endtask

    task automatic test_partial_store;
        int lat; logic [31:0] rd; logic er, idle;
        logic        tw  [3];
        logic [31:0] twd [3];
        logic [3:0]  tbe [3];
        logic [31:0] texp [3];
        tbe[0] = 4'b0001; twd[0] = 32'h0000_00AA; texp[0] = 32'hDEAD_BEAA;
        tbe[1] = 4'b0000; twd[1] = 32'hFFFF_FFFF; texp[1] = 32'hDEAD_BEAA;
        tbe[2] = 4'b0100; twd[2] = 32'h0055_0000; texp[2] = 32'hDE55_BEAA;
        tw[0] = 1'b1; tw[1] = 1'b1; tw[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_xact(tw[k], 32'h10, twd[k], tbe[k], lat, rd, er, idle);
            vectors++;
            if (er !== 1'b0 || rd !== 32'h0 || lat !== 2) begin
                miscompares++;
                $display("FAIL partial_store%0d got lat=%0d rdata=%08h err=%b want lat=2 rdata=0 err=0", k, lat, rd, er);
            end
            run_xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, idle);
            vectors++;
            if (rd !== texp[k] || er !== 1'b0) begin
                miscompares++;
                $display("FAIL partial_load%0d got rdata=%08h err=%b want rdata=%08h err=0", k, rd, er, texp[k]);
            end
        end
    endtask

    task automatic test_faults;
        int lat; logic [31:0] rd; logic er, idle;
        run_xact(1'b1, 32'h0, 32'h1234_5678, 4'hF, lat, rd, er, idle);
        run_xact(1'b0, 32'h13, 32'h0, 4'h0, lat, rd, er, idle);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 2 || idle !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_load got lat=%0d rdata=%08h err=%b idle=%b want lat=2 rdata=0 err=1 idle=1", lat, rd, er, idle);
        end
        run_xact(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, lat, rd, er, idle);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            miscompares++; $display("FAIL range_store got rdata=%08h err=%b want rdata=0 err=1", rd, er);
        end
        run_xact(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er, idle);
        vectors++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin
            miscompares++; $display("FAIL range_no_alias got rdata=%08h err=%b want rdata=12345678 err=0", rd, er);
        end
        run_xact(1'b1, 32'h12, 32'h0, 4'hF, lat, rd, er, idle);
        vectors++;
        if (er !== 1'b1) begin
            miscompares++; $display("FAIL misalign_store got err=%b want err=1", er);
        end
        run_xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, idle);
        vectors++;
        if (rd !== 32'hDE55_BEAA) begin
            miscompares++; $display("FAIL misalign_no_write got rdata=%08h want de55beaa", rd);
        end
        run_xact(1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, lat, rd, er, idle);
        run_xact(1'b0, 32'h3FC, 32'h0, 4'h0, lat, rd, er, idle);
        vectors++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            miscompares++; $display("FAIL last_word got rdata=%08h err=%b want rdata=cafef00d err=0", rd, er);
        end
        run_xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, er, idle);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            miscompares++; $display("FAIL high_addr_range got rdata=%08h err=%b want rdata=0 err=1", rd, er);
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [31:0] rd; logic er, idle;
        int n;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'h0;
        @(posedge clk);
        #1;
        // A store offered while busy must be ignored.
        req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE55_BEAA || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold%0d got valid=%b rdata=%08h err=%b ready=%b want valid=1 rdata=de55beaa err=0 ready=0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        $display("xact backpressure load addr=00000010 released");
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
        end
        run_xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, idle);
        vectors++;
        if (rd !== 32'hDE55_BEAA) begin
            miscompares++; $display("FAIL busy_store_ignored got rdata=%08h want de55beaa", rd);
        end
    endtask

    task automatic test_reset_mid_wait;
        int lat; logic [31:0] rd; logic er, idle;
        logic seen;
        logic        tw [2];
        logic [31:0] ta [2];
        tw[0] = 1'b0; ta[0] = 32'h10;
        tw[1] = 1'b1; ta[1] = 32'h20;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = tw[k]; req_addr = ta[k]; req_wdata = 32'h5A5A_5A5A; req_be = 4'hF;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            $display("xact reset during WAIT we=%0b addr=%08h", tw[k], ta[k]);
            vectors++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_mid_wait%0d got valid=%b ready=%b want valid=0 ready=1", k, rsp_valid, req_ready);
            end
            @(negedge clk);
            rst_n = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            vectors++;
            if (seen !== 1'b0) begin
                miscompares++; $display("FAIL reset_no_response%0d got rsp_valid seen=%b want 0", k, seen);
            end
        end
        run_xact(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, idle);
        vectors++;
        if (rd !== 32'h5A5A_5A5A || er !== 1'b0) begin
            miscompares++; $display("FAIL reset_store_kept got rdata=%08h err=%b want rdata=5a5a5a5a err=0", rd, er);
        end
    endtask

    task automatic test_back_to_back_lat0;
        logic        tw   [5];
        logic [31:0] ta   [5];
        logic [31:0] texp [5];
        logic        terr [5];
        tw[0] = 1'b1; ta[0] = 32'h04; texp[0] = 32'h0;         terr[0] = 1'b0;
        tw[1] = 1'b0; ta[1] = 32'h04; texp[1] = 32'h1111_1111; terr[1] = 1'b0;
        tw[2] = 1'b0; ta[2] = 32'h44; texp[2] = 32'h0;         terr[2] = 1'b1;
        tw[3] = 1'b0; ta[3] = 32'h04; texp[3] = 32'h1111_1111; terr[3] = 1'b0;
        tw[4] = 1'b0; ta[4] = 32'h04; texp[4] = 32'h1111_1111; terr[4] = 1'b0;
        @(negedge clk);
        req_valid0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_we0 = tw[k]; req_addr0 = ta[k]; req_wdata0 = 32'h1111_1111; req_be0 = 4'hF;
            vectors++;
            if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_accept_slot%0d got ready=%b valid=%b want ready=1 valid=0", k, req_ready0, rsp_valid0);
            end
            @(negedge clk);
            $display("xact lat0 we=%0b addr=%08h -> valid=%0b rdata=%08h err=%0b ready=%0b",
                     tw[k], ta[k], rsp_valid0, rsp_rdata0, rsp_err0, req_ready0);
            vectors++;
            if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== texp[k] || rsp_err0 !== terr[k] || req_ready0 !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_resp%0d got valid=%b rdata=%08h err=%b ready=%b want valid=1 rdata=%08h err=%b ready=0",
                         k, rsp_valid0, rsp_rdata0, rsp_err0, req_ready0, texp[k], terr[k]);
            end
            @(negedge clk);
        end
        req_valid0 = 1'b0;
`ifdef DMEM_STATS_EN
        vectors++;
        if (stat_loads0 !== 16'd3 || stat_stores0 !== 16'd1 || stat_errs0 !== 16'd1) begin
            miscompares++;
            $display("FAIL stats_count got loads=%0d stores=%0d errs=%0d want loads=3 stores=1 errs=1",
                     stat_loads0, stat_stores0, stat_errs0);
        end
        stat_clr0 = 1'b1;
        @(negedge clk);
        stat_clr0 = 1'b0;
        vectors++;
        if (stat_loads0 !== 16'd0 || stat_stores0 !== 16'd0 || stat_errs0 !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_clear got loads=%0d stores=%0d errs=%0d want all 0",
                     stat_loads0, stat_stores0, stat_errs0);
        end
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_store_load();
        test_partial_store();
        test_faults();
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back_lat0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
